ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL expose parameter IO_BUS_SIZE, default 32, data/address bus width.
REQ-002 The block SHALL expose parameter REG_ADDR_SIZE, default 5, register-file address width.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-low.
REQ-005 i_enable  in  1  pipeline advance; 0 = stall (hold contents).
REQ-006 i_flush  in  1  synchronous bubble insert.
REQ-007 i_valid  in  1  EX stage holds a real instruction.
REQ-008 i_halt  in  1  EX instruction is HALT.
REQ-009 i_mem_wr_rd  in  1  1 = store, 0 = load/no access.
REQ-010 i_mem_wr_src  in  2  store width: 0 word, 1 halfword, 2 byte.
REQ-011 i_mem_rd_src  in  3  load format: 0 word, 1 sext half, 2 sext byte, 3 uext half, 4 uext byte.
REQ-012 i_reg_wr, i_mem_to_reg  in  1 each  writeback controls.
REQ-013 i_wb_addr  in  REG_ADDR_SIZE  destination register.
REQ-014 i_alu_res, i_bus_b  in  IO_BUS_SIZE  effective address / store data.
REQ-015 Outputs o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_reg_wr, o_mem_to_reg, o_wb_addr, o_alu_res, o_bus_b SHALL be registered copies of the matching inputs.
REQ-016 o_valid  out  1  registered instruction valid; o_halt  out  1  sticky halt flag.

Function
REQ-017 Latency SHALL be exactly one cycle from input to output when enabled; all outputs driven directly from flops.
REQ-018 Priority per edge SHALL be: reset > HALTED state > i_flush > i_enable > hold.
REQ-019 Capture with i_valid=0 SHALL load a bubble: o_valid, o_mem_wr_rd, o_reg_wr, o_mem_to_reg = 0; data fields captured unchanged.
REQ-020 Bubble SHALL never produce a store or register write regardless of other control inputs.
REQ-021 i_flush=1 SHALL load a bubble with all data fields and selectors = 0, independent of i_enable.
REQ-022 i_enable=0 and i_flush=0 SHALL hold every output unchanged, including o_valid.
REQ-023 FSM states SHALL be RUN, HALT_HEAD, HALTED; reset enters RUN.
REQ-024 RUN -> HALT_HEAD when a capture occurs with i_valid=1, i_halt=1, i_flush=0; halt instruction captured as a bubble carrying o_valid=1, controls 0.
REQ-025 HALT_HEAD -> HALTED unconditionally next edge, loading a bubble.
REQ-026 HALTED SHALL hold the bubble, ignore i_enable, i_flush, i_valid, and stay until reset.
REQ-027 o_halt SHALL be 1 in HALT_HEAD and HALTED, 0 in RUN.
REQ-028 Halt with i_enable=0 SHALL not be captured; transition occurs on the first enabled edge.

Reset
REQ-029 Asserting i_reset SHALL immediately, without clock, clear all outputs and counters to 0 and force RUN.
REQ-030 Reset mid-stall or in HALTED SHALL discard held contents; first enabled edge after deassertion captures normally.

Configuration
REQ-031 Macro EX_MEM_PERF_EN, when defined, SHALL add outputs o_retired_cnt and o_stall_cnt, each 32 bits.
REQ-032 With EX_MEM_PERF_EN: o_retired_cnt increments on each RUN-state capture with i_valid=1 and i_flush=0; o_stall_cnt increments each RUN-state cycle with i_enable=0 and o_valid=1; both wrap from 0xFFFFFFFF to 0 and freeze outside RUN.
REQ-033 Without EX_MEM_PERF_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset low, then high; enable=1, valid=1, reg_wr=1, wb_addr=5, alu_res=0x10 -> next edge o_reg_wr=1, o_wb_addr=5, o_alu_res=0x10, o_valid=1.
REQ-035 Load word captured, then enable=0 for 3 cycles with changing inputs -> outputs unchanged 3 cycles; o_stall_cnt=3 when PERF enabled.
REQ-036 enable=1, flush=1, mem_wr_rd=1, bus_b=0xDEADBEEF -> o_mem_wr_rd=0, o_bus_b=0, o_valid=0.
REQ-037 valid=1, halt=1 captured -> o_halt=1 same edge; next edge bubble; then 10 cycles of valid stores with flush toggling -> o_mem_wr_rd stays 0, o_halt stays 1.
REQ-038 Assert i_reset between clock edges while in HALTED -> o_halt, o_valid, counters go 0 before next edge.
REQ-039 valid=0, reg_wr=1, mem_wr_rd=1 captured -> o_reg_wr=0, o_mem_wr_rd=0, o_retired_cnt unchanged.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline register bus: EX-side controls/data in, MEM-side registered copies out.
// Defining EX_MEM_PERF_EN adds the retired/stall performance counter outputs.
interface ex_mem_if #(
  parameter int unsigned IO_BUS_SIZE   = 32,
  parameter int unsigned REG_ADDR_SIZE = 5
);
  logic                     i_enable;
  logic                     i_flush;
  logic                     i_valid;
  logic                     i_halt;
  logic                     i_mem_wr_rd;
  logic [1:0]               i_mem_wr_src;
  logic [2:0]               i_mem_rd_src;
  logic                     i_reg_wr;
  logic                     i_mem_to_reg;
  logic [REG_ADDR_SIZE-1:0] i_wb_addr;
  logic [IO_BUS_SIZE-1:0]   i_alu_res;
  logic [IO_BUS_SIZE-1:0]   i_bus_b;

  logic                     o_valid;
  logic                     o_halt;
  logic                     o_mem_wr_rd;
  logic [1:0]               o_mem_wr_src;
  logic [2:0]               o_mem_rd_src;
  logic                     o_reg_wr;
  logic                     o_mem_to_reg;
  logic [REG_ADDR_SIZE-1:0] o_wb_addr;
  logic [IO_BUS_SIZE-1:0]   o_alu_res;
  logic [IO_BUS_SIZE-1:0]   o_bus_b;
`ifdef EX_MEM_PERF_EN
  logic [31:0]              o_retired_cnt;
  logic [31:0]              o_stall_cnt;
`endif

  modport master (
    output i_enable, i_flush, i_valid, i_halt, i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src,
           i_reg_wr, i_mem_to_reg, i_wb_addr, i_alu_res, i_bus_b,
`ifdef EX_MEM_PERF_EN
    input  o_retired_cnt, o_stall_cnt,
`endif
    input  o_valid, o_halt, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src,
           o_reg_wr, o_mem_to_reg, o_wb_addr, o_alu_res, o_bus_b
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_halt, i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src,
           i_reg_wr, i_mem_to_reg, i_wb_addr, i_alu_res, i_bus_b,
`ifdef EX_MEM_PERF_EN
    output o_retired_cnt, o_stall_cnt,
`endif
    output o_valid, o_halt, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src,
           o_reg_wr, o_mem_to_reg, o_wb_addr, o_alu_res, o_bus_b
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall, flush, bubble insertion and a sticky HALT sequence.
// Optional feature macro: EX_MEM_PERF_EN (retired-instruction and stall counters).
module ex_mem #(
  parameter int unsigned IO_BUS_SIZE   = 32,
  parameter int unsigned REG_ADDR_SIZE = 5
) (
  input  logic     i_clk,
  input  logic     i_reset,
  ex_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_HEAD = 2'd1,
    HALTED    = 2'd2
  } state_e;

  typedef struct packed {
    logic                     mem_wr_rd;
    logic [1:0]               mem_wr_src;
    logic [2:0]               mem_rd_src;
    logic                     reg_wr;
    logic                     mem_to_reg;
    logic [REG_ADDR_SIZE-1:0] wb_addr;
    logic [IO_BUS_SIZE-1:0]   alu_res;
    logic [IO_BUS_SIZE-1:0]   bus_b;
  } payload_t;

  state_e   state_q;
  payload_t pl_q;
  logic     valid_q;
  logic     halt_q;
  logic     real_op_c;

  // Only a valid, non-HALT instruction may carry a store or register write.
  assign real_op_c = bus.i_valid && !bus.i_halt;

  // Pipeline register and halt sequencing.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      pl_q    <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.i_flush) begin
            pl_q    <= '0;
            valid_q <= 1'b0;
          end else if (bus.i_enable) begin
            pl_q.mem_wr_rd  <= real_op_c && bus.i_mem_wr_rd;
            pl_q.mem_wr_src <= bus.i_mem_wr_src;
            pl_q.mem_rd_src <= bus.i_mem_rd_src;
            pl_q.reg_wr     <= real_op_c && bus.i_reg_wr;
            pl_q.mem_to_reg <= real_op_c && bus.i_mem_to_reg;
            pl_q.wb_addr    <= bus.i_wb_addr;
            pl_q.alu_res    <= bus.i_alu_res;
            pl_q.bus_b      <= bus.i_bus_b;
            valid_q         <= bus.i_valid;
            if (bus.i_valid && bus.i_halt) begin
              state_q <= HALT_HEAD;
              halt_q  <= 1'b1;
            end
          end
        end
        HALT_HEAD: begin
          pl_q    <= '0;
          valid_q <= 1'b0;
          state_q <= HALTED;
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= RUN;
          pl_q    <= '0;
          valid_q <= 1'b0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_halt       = halt_q;
  assign bus.o_mem_wr_rd  = pl_q.mem_wr_rd;
  assign bus.o_mem_wr_src = pl_q.mem_wr_src;
  assign bus.o_mem_rd_src = pl_q.mem_rd_src;
  assign bus.o_reg_wr     = pl_q.reg_wr;
  assign bus.o_mem_to_reg = pl_q.mem_to_reg;
  assign bus.o_wb_addr    = pl_q.wb_addr;
  assign bus.o_alu_res    = pl_q.alu_res;
  assign bus.o_bus_b      = pl_q.bus_b;

`ifdef EX_MEM_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Counters run only in RUN and wrap naturally at 32 bits.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else if (state_q == RUN) begin
      if (bus.i_enable && !bus.i_flush && bus.i_valid) retired_q <= retired_q + 32'd1;
      if (!bus.i_enable && valid_q)                    stall_q   <= stall_q + 32'd1;
    end
  end

  assign bus.o_retired_cnt = retired_q;
  assign bus.o_stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized traffic against a rule-level model.
module tb_ex_mem;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned VW = 1 + 1 + 1 + 2 + 3 + 1 + 1 + RW + AW + AW;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ex_mem_if #(.IO_BUS_SIZE(AW), .REG_ADDR_SIZE(RW)) bus ();

  ex_mem #(.IO_BUS_SIZE(AW), .REG_ADDR_SIZE(RW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected outputs plus a halt phase (0 running, 1 just halted, 2 parked).
  int                  m_phase;
  logic                e_valid, e_halt, e_wr_rd, e_reg_wr, e_m2r;
  logic [1:0]          e_wr_src;
  logic [2:0]          e_rd_src;
  logic [RW-1:0]       e_wb;
  logic [AW-1:0]       e_alu, e_busb;
  logic [31:0]         e_ret, e_stall;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.o_valid, bus.o_halt, bus.o_mem_wr_rd, bus.o_mem_wr_src, bus.o_mem_rd_src,
            bus.o_reg_wr, bus.o_mem_to_reg, bus.o_wb_addr, bus.o_alu_res, bus.o_bus_b};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_valid, e_halt, e_wr_rd, e_wr_src, e_rd_src, e_reg_wr, e_m2r, e_wb, e_alu, e_busb};
  endfunction

  task automatic model_clear();
    m_phase = 0;
    {e_valid, e_halt, e_wr_rd, e_reg_wr, e_m2r} = '0;
    e_wr_src = '0; e_rd_src = '0; e_wb = '0; e_alu = '0; e_busb = '0;
    e_ret = 32'd0; e_stall = 32'd0;
  endtask

  task automatic model_bubble_zero();
    {e_valid, e_wr_rd, e_reg_wr, e_m2r} = '0;
    e_wr_src = '0; e_rd_src = '0; e_wb = '0; e_alu = '0; e_busb = '0;
  endtask

  task automatic model_edge();
    logic useful;
    if (m_phase == 2) return;
    if (m_phase == 1) begin
      model_bubble_zero();
      m_phase = 2;
      return;
    end
    if (bus.i_enable && !bus.i_flush && bus.i_valid) e_ret = e_ret + 32'd1;
    if (!bus.i_enable && e_valid) e_stall = e_stall + 32'd1;
    if (bus.i_flush) begin
      model_bubble_zero();
    end else if (bus.i_enable) begin
      useful   = bus.i_valid && !bus.i_halt;
      e_valid  = bus.i_valid;
      e_wr_rd  = useful ? bus.i_mem_wr_rd : 1'b0;
      e_reg_wr = useful ? bus.i_reg_wr : 1'b0;
      e_m2r    = useful ? bus.i_mem_to_reg : 1'b0;
      e_wr_src = bus.i_mem_wr_src;
      e_rd_src = bus.i_mem_rd_src;
      e_wb     = bus.i_wb_addr;
      e_alu    = bus.i_alu_res;
      e_busb   = bus.i_bus_b;
      if (bus.i_valid && bus.i_halt) begin
        m_phase = 1;
        e_halt  = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.i_enable = 1'b0; bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_halt = 1'b0;
    bus.i_mem_wr_rd = 1'b0; bus.i_mem_wr_src = 2'd0; bus.i_mem_rd_src = 3'd0;
    bus.i_reg_wr = 1'b0; bus.i_mem_to_reg = 1'b0; bus.i_wb_addr = '0;
    bus.i_alu_res = '0; bus.i_bus_b = '0;
  endtask

  task automatic drive_random(input bit allow_halt);
    bus.i_enable     = ($urandom_range(3) != 0);
    bus.i_flush      = ($urandom_range(7) == 0);
    bus.i_valid      = ($urandom_range(3) != 0);
    bus.i_halt       = allow_halt ? ($urandom_range(15) == 0) : 1'b0;
    bus.i_mem_wr_rd  = 1'($urandom);
    bus.i_mem_wr_src = 2'($urandom_range(2));
    bus.i_mem_rd_src = 3'($urandom_range(4));
    bus.i_reg_wr     = 1'($urandom);
    bus.i_mem_to_reg = 1'($urandom);
    bus.i_wb_addr    = RW'($urandom);
    bus.i_alu_res    = AW'($urandom);
    bus.i_bus_b      = AW'($urandom);
  endtask

  // Async reset pulse placed mid-cycle, released on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_reset_clear: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_clear();
    #3;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
`ifdef EX_MEM_PERF_EN
    vectors++;
    if (bus.o_retired_cnt !== 32'd0 || bus.o_stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.o_retired_cnt, bus.o_stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_capture();
    bus.i_enable = 1'b1; bus.i_valid = 1'b1; bus.i_reg_wr = 1'b1;
    bus.i_wb_addr = RW'(5); bus.i_alu_res = AW'(32'h10);
    tick();
    vectors++;
    if (bus.o_reg_wr !== 1'b1 || bus.o_wb_addr !== RW'(5) || bus.o_alu_res !== AW'(32'h10) || bus.o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_capture: got reg_wr=%b wb=%0d alu=%h valid=%b want 1/5/10/1",
               bus.o_reg_wr, bus.o_wb_addr, bus.o_alu_res, bus.o_valid);
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL basic_full: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    pulse_reset();
    drive_idle();
    bus.i_enable = 1'b1; bus.i_valid = 1'b1; bus.i_reg_wr = 1'b1; bus.i_mem_to_reg = 1'b1;
    bus.i_mem_rd_src = 3'd0; bus.i_wb_addr = RW'(9); bus.i_alu_res = AW'(32'h0000_0400);
    tick();
    snap = dut_vec();
    vectors++;
    if (snap !== exp_vec()) begin
      miscompares++;
      $display("FAIL stall_load_capture: got %h want %h", snap, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b1);
      bus.i_enable = 1'b0;
      bus.i_flush  = 1'b0;
      tick();
      vectors++;
      if (dut_vec() !== snap || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec(), snap);
      end
    end
`ifdef EX_MEM_PERF_EN
    vectors++;
    if (bus.o_stall_cnt !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_count: got %0d want 3", bus.o_stall_cnt);
    end
`endif
  endtask

  task automatic test_flush();
    drive_idle();
    bus.i_enable = 1'b1; bus.i_flush = 1'b1; bus.i_valid = 1'b1;
    bus.i_mem_wr_rd = 1'b1; bus.i_bus_b = AW'(32'hDEAD_BEEF); bus.i_alu_res = AW'(32'h1234);
    tick();
    vectors++;
    if (bus.o_mem_wr_rd !== 1'b0 || bus.o_bus_b !== '0 || bus.o_valid !== 1'b0 || bus.o_alu_res !== '0) begin
      miscompares++;
      $display("FAIL flush_bubble: got wr_rd=%b bus_b=%h valid=%b alu=%h want 0/0/0/0",
               bus.o_mem_wr_rd, bus.o_bus_b, bus.o_valid, bus.o_alu_res);
    end
    bus.i_enable = 1'b0;
    tick();
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL flush_no_enable: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_bubble();
    logic [31:0] ret_before;
`ifdef EX_MEM_PERF_EN
    ret_before = bus.o_retired_cnt;
`else
    ret_before = 32'd0;
`endif
    drive_idle();
    bus.i_enable = 1'b1; bus.i_valid = 1'b0; bus.i_reg_wr = 1'b1; bus.i_mem_wr_rd = 1'b1;
    bus.i_mem_to_reg = 1'b1; bus.i_alu_res = AW'(32'hCAFE_0001); bus.i_wb_addr = RW'(17);
    tick();
    vectors++;
    if (bus.o_reg_wr !== 1'b0 || bus.o_mem_wr_rd !== 1'b0 || bus.o_mem_to_reg !== 1'b0 ||
        bus.o_valid !== 1'b0 || bus.o_alu_res !== AW'(32'hCAFE_0001) || bus.o_wb_addr !== RW'(17)) begin
      miscompares++;
      $display("FAIL invalid_bubble: got %h want ctrl 0 with alu=cafe0001 wb=17", dut_vec());
    end
`ifdef EX_MEM_PERF_EN
    vectors++;
    if (bus.o_retired_cnt !== ret_before) begin
      miscompares++;
      $display("FAIL bubble_retired: got %0d want %0d", bus.o_retired_cnt, ret_before);
    end
`else
    if (ret_before != 32'd0) $display("note: unexpected counter state");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_random(1'b0);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
`ifdef EX_MEM_PERF_EN
      vectors++;
      if (bus.o_retired_cnt !== e_ret || bus.o_stall_cnt !== e_stall) begin
        miscompares++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                 bus.o_retired_cnt, bus.o_stall_cnt, e_ret, e_stall);
      end
`endif
    end
  endtask

  task automatic test_halt();
    drive_idle();
    bus.i_valid = 1'b1; bus.i_halt = 1'b1; bus.i_reg_wr = 1'b1; bus.i_mem_wr_rd = 1'b1;
    bus.i_enable = 1'b0;
    tick();
    vectors++;
    if (bus.o_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_stalled: got o_halt=%b want 0", bus.o_halt);
    end
    bus.i_enable = 1'b1;
    tick();
    vectors++;
    if (bus.o_halt !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_reg_wr !== 1'b0 || bus.o_mem_wr_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_capture: got halt=%b valid=%b reg_wr=%b wr_rd=%b want 1/1/0/0",
               bus.o_halt, bus.o_valid, bus.o_reg_wr, bus.o_mem_wr_rd);
    end
    drive_random(1'b0);
    tick();
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_halt !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL halt_head_bubble: got %h want %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 10; i++) begin
      drive_random(1'b0);
      bus.i_valid = 1'b1; bus.i_mem_wr_rd = 1'b1; bus.i_flush = 1'(i % 2);
      tick();
      vectors++;
      if (bus.o_mem_wr_rd !== 1'b0 || bus.o_halt !== 1'b1 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL halted_hold[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_recover();
    pulse_reset();
    drive_idle();
    bus.i_enable = 1'b1; bus.i_valid = 1'b1; bus.i_mem_wr_rd = 1'b1; bus.i_mem_wr_src = 2'd2;
    bus.i_alu_res = AW'(32'h8000_0000); bus.i_bus_b = AW'(32'h0000_00A5);
    tick();
    vectors++;
    if (dut_vec() !== exp_vec() || bus.o_mem_wr_rd !== 1'b1 || bus.o_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL post_halt_reset_capture: got %h want %h", dut_vec(), exp_vec());
    end
    bus.i_enable = 1'b0;
    tick();
    tick();
    pulse_reset();
    bus.i_enable = 1'b1; bus.i_valid = 1'b1; bus.i_reg_wr = 1'b1; bus.i_wb_addr = RW'(31);
    tick();
    vectors++;
    if (dut_vec() !== exp_vec() || bus.o_wb_addr !== RW'(31)) begin
      miscompares++;
      $display("FAIL post_stall_reset_capture: got %h want %h", dut_vec(), exp_vec());
    end
`ifdef EX_MEM_PERF_EN
    vectors++;
    if (bus.o_retired_cnt !== 32'd1 || bus.o_stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_counters: got %0d/%0d want 1/0", bus.o_retired_cnt, bus.o_stall_cnt);
    end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_capture();
    test_stall();
    test_flush();
    test_bubble();
    test_random();
    test_halt();
    test_reset_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
